seq_detect_param: RTL and testbench
===================================

# seq_detect_param

Parametrised serial bit-pattern detector, the generalised successor to the fixed 4-bit Mealy detector in the Mealy–Moore lab. It takes a serial `din` stream, gated by `en`, and matches it against a compile-time `PATTERN` of `PAT_W` bits, with overlapping or non-overlapping detection. On each match it raises a registered one-cycle `det` pulse and can optionally count matches. It sits directly after the input synchroniser / debouncer and feeds LED/7-segment display logic.

## Interface
- `PAT_W`, default 4: pattern length in bits, legal range 2..16.
- `PATTERN`, default 4'b1011: target sequence. Bit `PAT_W-1` is expected first on `din`.
- `OVERLAP`, default 1: 1 means the trailing bits of a match may start the next match; 0 means matching restarts from empty after every hit.
- `CNT_W`, default 8: match-counter width (used only when the counter is compiled in).
- `clk`  in  1  sole clock; all logic on rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `en`  in  1  sample enable; `din` is consumed only when `en`=1.
- `din`  in  1  serial data bit.
- `clr_cnt`  in  1  synchronous clear of `match_cnt` (port present only with the counter).
- `det`  out  1  registered match pulse.
- `pfx_len`  out  $clog2(PAT_W)  current matched-prefix length, 0..PAT_W-1.
- `match_cnt`  out  CNT_W  saturating match count (present only with the counter).

## Operation
- The state is `pfx_len` = k, the length of the longest prefix of `PATTERN` that is a suffix of the bits accepted so far. There are exactly `PAT_W` states, S0..S(PAT_W-1).
- Define `exp(k)` = `PATTERN[PAT_W-1-k]`, the next bit the pattern expects.
- When `en`=1 and `din`==`exp(k)` with k+1<`PAT_W`:
  - k <= k+1
  - `det` <= 0
- When `en`=1 and `din`==`exp(k)` with k+1==`PAT_W` (a full match):
  - `det` <= 1
  - k <= `OVERLAP` ? fail(`PAT_W`) : 0, where fail(n) is the longest proper prefix of the first n pattern bits that is also a suffix of them.
- When `en`=1 and `din`!=`exp(k)`: k <= the largest j ≤ k such that the first j-1 pattern bits followed by `din` equal the last j accepted bits (KMP fallback). `det` <= 0.
- When `en`=0: k holds and `det` <= 0.
- The fallback and fail tables are computed at elaboration time from `PATTERN`. There are no runtime tables.
- Example, PATTERN=1011 with OVERLAP=1: a match returns to S1. For 10 then 0, the fallback goes to S0. For 1 then 1, the state stays in S1.

## Timing
- Reset values: `pfx_len`=0, `det`=0, `match_cnt`=0. Reset overrides `en`, `din` and `clr_cnt`.
- Latency: `det` goes high in the cycle after the edge that samples the final pattern bit, and stays high for exactly 1 cycle per match.
- Back-to-back `det` pulses are possible only when OVERLAP=1 and fail(`PAT_W`)==`PAT_W`-1, e.g. PATTERN=11 on a stream of 1s.
- Reset asserted mid-pattern discards the partial match. The first `din` accepted after reset is compared against `exp(0)`.

## Configuration
- `SEQDET_MATCH_COUNT_EN` defined:
  - `match_cnt` and `clr_cnt` exist.
  - The counter increments on the same edge that sets `det`=1 and saturates at 2^CNT_W-1, with no wrap.
  - `clr_cnt`=1 forces the count to 0 and wins over a simultaneous increment.
- `SEQDET_MATCH_COUNT_EN` undefined: neither port exists, no counter flops are generated, and detector behaviour is identical.

## Structure
- Package `seqdet_pkg` holds:
  - the elaboration-time functions `seqdet_fail(pattern, width, n)` and `seqdet_next(pattern, width, k, bit)`
  - the constant `SEQDET_MAX_W = 16`
- Sub-module `seqdet_sat_counter` (parameter `W`; ports `clk`, `rst`, `inc`, `clr`, `cnt`) is instantiated under the macro.
- The state register and `det` flop live in the top module.

## Test plan
- Default 1011 with OVERLAP=1, `en`=1, stream 1,0,1,1,0,1,1 -> `det` pulses in the cycles after bits 4 and 7. `match_cnt`=2.
- Same stream with OVERLAP=0 -> a single `det` pulse after bit 4. `pfx_len` returns to 0 after the match.
- PATTERN=4'b1011, stream 1,0,1,0,1,1 -> the fallback S3->S2 on the fourth bit is observed in `pfx_len`. `det` fires after bit 6.
- `en` toggled: the bits 1,0,1,1 are presented with `en`=0 cycles interleaved -> `pfx_len` holds across the gaps and `det` fires exactly once.
- `rst` asserted while `pfx_len`=3, then 1 applied -> `pfx_len`=1 and `det`=0. `match_cnt`=0 after the reset.
- CNT_W=2 with 5 matches -> `match_cnt` saturates at 3. `clr_cnt` asserted on the same cycle as a match -> `match_cnt`=0.

Source files
------------

// File: rtl/seqdet_pkg.sv
// Shared constants and elaboration-time pattern-matching helpers for seq_detect_param.
// Bit (width-1) of a pattern is the first bit expected on the serial input.
package seqdet_pkg;

    localparam int SEQDET_MAX_W = 16;

    typedef logic [SEQDET_MAX_W-1:0] seqdet_pat_t;

    // i-th pattern bit in arrival order (i = 0 is the first bit on the wire)
    function automatic logic seqdet_bit(seqdet_pat_t pattern, int width, int i);
        seqdet_pat_t t;
        t = pattern >> (width - 1 - i);
        return t[0];
    endfunction

    // Longest proper prefix of the first n pattern bits that is also their suffix.
    function automatic int seqdet_fail(seqdet_pat_t pattern, int width, int n);
        int  best;
        logic ok;
        best = 0;
        for (int l = 1; l < n; l++) begin
            ok = 1'b1;
            for (int t = 0; t < l; t++) begin
                if (seqdet_bit(pattern, width, t) != seqdet_bit(pattern, width, n - l + t))
                    ok = 1'b0;
            end
            if (ok)
                best = l;
        end
        return best;
    endfunction

    // Longest pattern prefix that is a suffix of (first k pattern bits, then b).
    function automatic int seqdet_next(seqdet_pat_t pattern, int width, int k, logic b);
        int   best;
        int   idx;
        logic ok;
        logic s;
        best = 0;
        for (int j = 1; j <= k + 1; j++) begin
            ok = 1'b1;
            for (int t = 0; t < j; t++) begin
                idx = k + 1 - j + t;
                s   = (idx == k) ? b : seqdet_bit(pattern, width, idx);
                if (seqdet_bit(pattern, width, t) != s)
                    ok = 1'b0;
            end
            if (ok)
                best = j;
        end
        return best;
    endfunction

endpackage

// File: rtl/seqdet_sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats a simultaneous increment.
module seqdet_sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (rst || clr)
            cnt <= '0;
        else if (inc && (cnt != '1))
            cnt <= cnt + W'(1);
    end

endmodule

// File: rtl/seq_detect_param.sv
// Parametrised serial pattern detector (KMP state = matched-prefix length).
// Define SEQDET_MATCH_COUNT_EN to add the clr_cnt / match_cnt saturating match counter.
//
// state        | meaning
// S0           | no useful prefix held
// Sk (0<k<W)   | last k accepted bits equal the first k pattern bits
module seq_detect_param
    import seqdet_pkg::*;
#(
    parameter int              PAT_W   = 4,
    parameter logic [PAT_W-1:0] PATTERN = 4'b1011,
    parameter int              OVERLAP = 1,
    parameter int              CNT_W   = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     din,
    output logic                     det,
    output logic [$clog2(PAT_W)-1:0] pfx_len
`ifdef SEQDET_MATCH_COUNT_EN
    ,
    input  logic                     clr_cnt,
    output logic [CNT_W-1:0]         match_cnt
`endif
);

    localparam int          K_W     = $clog2(PAT_W);
    localparam seqdet_pat_t PAT_EXT = seqdet_pat_t'(PATTERN);
    localparam int          MATCH_K = (OVERLAP != 0) ? seqdet_fail(PAT_EXT, PAT_W, PAT_W) : 0;

    if (PAT_W < 2 || PAT_W > SEQDET_MAX_W || CNT_W < 1) begin : g_bad_param
        $error("seq_detect_param: PAT_W must be 2..16 and CNT_W at least 1");
    end

    logic [PAT_W-1:0] exp_vec;
    logic [K_W-1:0]   nxt0 [PAT_W];
    logic [K_W-1:0]   nxt1 [PAT_W];
    logic [K_W-1:0]   pfx_nxt;
    logic             det_nxt;

    // Transition tables are pure constants; the full-match entry folds in the overlap restart.
    for (genvar g = 0; g < PAT_W; g++) begin : g_tbl
        localparam logic EXP = PATTERN[PAT_W-1-g];
        localparam int   N0  = (g == PAT_W-1 && !EXP) ? MATCH_K : seqdet_next(PAT_EXT, PAT_W, g, 1'b0);
        localparam int   N1  = (g == PAT_W-1 &&  EXP) ? MATCH_K : seqdet_next(PAT_EXT, PAT_W, g, 1'b1);
        assign exp_vec[g] = EXP;
        assign nxt0[g]    = K_W'(N0);
        assign nxt1[g]    = K_W'(N1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pfx_len <= '0;
            det     <= 1'b0;
        end else begin
            pfx_len <= pfx_nxt;
            det     <= det_nxt;
        end
    end

    always_comb begin
        pfx_nxt = pfx_len;
        det_nxt = 1'b0;
        if (en) begin
            pfx_nxt = din ? nxt1[pfx_len] : nxt0[pfx_len];
            det_nxt = (pfx_len == K_W'(PAT_W - 1)) && (din == exp_vec[pfx_len]);
        end
    end

`ifdef SEQDET_MATCH_COUNT_EN
    seqdet_sat_counter #(
        .W (CNT_W)
    ) u_cnt (
        .clk (clk),
        .rst (rst),
        .inc (det_nxt),
        .clr (clr_cnt),
        .cnt (match_cnt)
    );
`endif

endmodule

// File: tb/tb_seq_detect_param.sv
// Self-checking bench for seq_detect_param: three configurations share one stimulus stream.
module tb_seq_detect_param;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en  = 1'b0;
    logic din = 1'b0;

    logic       a_det, b_det, c_det;
    logic [1:0] a_pfx, b_pfx;
    logic [0:0] c_pfx;
`ifdef SEQDET_MATCH_COUNT_EN
    logic       clr = 1'b0;
    logic [7:0] a_cnt, b_cnt;
    logic [1:0] c_cnt;
`endif

    always #5 clk = ~clk;

    seq_detect_param #(.PAT_W(4), .PATTERN(4'b1011), .OVERLAP(1), .CNT_W(8)) dut_a (
        .clk(clk), .rst(rst), .en(en), .din(din), .det(a_det), .pfx_len(a_pfx)
`ifdef SEQDET_MATCH_COUNT_EN
        , .clr_cnt(clr), .match_cnt(a_cnt)
`endif
    );

    seq_detect_param #(.PAT_W(4), .PATTERN(4'b1011), .OVERLAP(0), .CNT_W(8)) dut_b (
        .clk(clk), .rst(rst), .en(en), .din(din), .det(b_det), .pfx_len(b_pfx)
`ifdef SEQDET_MATCH_COUNT_EN
        , .clr_cnt(clr), .match_cnt(b_cnt)
`endif
    );

    seq_detect_param #(.PAT_W(2), .PATTERN(2'b11), .OVERLAP(1), .CNT_W(2)) dut_c (
        .clk(clk), .rst(rst), .en(en), .din(din), .det(c_det), .pfx_len(c_pfx)
`ifdef SEQDET_MATCH_COUNT_EN
        , .clr_cnt(clr), .match_cnt(c_cnt)
`endif
    );

    typedef struct {
        logic rst, en, din, clr;
        logic a_det; int a_pfx;
        logic b_det; int b_pfx;
        logic c_det; int c_pfx;
        int   a_cnt; int c_cnt;
        logic chk_c;
    } vec_t;

    int   errors = 0;
    int   checks = 0;
    vec_t vecs [38];
    vec_t sb [$];

    function automatic vec_t mk(logic r, logic e, logic d, logic c,
                                logic ad, int ap, logic bd, int bp, logic cd, int cp,
                                int ac, int cc);
        vec_t v;
        v.rst = r; v.en = e; v.din = d; v.clr = c;
        v.a_det = ad; v.a_pfx = ap; v.b_det = bd; v.b_pfx = bp;
        v.c_det = cd; v.c_pfx = cp; v.a_cnt = ac; v.c_cnt = cc;
        v.chk_c = 1'b1;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
        end
    endtask

    // Drive one cycle, queue its expectation, then compare after the edge.
    task automatic step(input vec_t v, input string tag);
        vec_t e;
        rst = v.rst; en = v.en; din = v.din;
`ifdef SEQDET_MATCH_COUNT_EN
        clr = v.clr;
`endif
        sb.push_back(v);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL %s scoreboard: got empty queue expected entry", tag);
        end else begin
            e = sb.pop_front();
            chk({tag, " a_det"}, 32'(a_det), 32'(e.a_det));
            chk({tag, " a_pfx"}, 32'(a_pfx), e.a_pfx);
            chk({tag, " b_det"}, 32'(b_det), 32'(e.b_det));
            chk({tag, " b_pfx"}, 32'(b_pfx), e.b_pfx);
            if (e.chk_c) begin
                chk({tag, " c_det"}, 32'(c_det), 32'(e.c_det));
                chk({tag, " c_pfx"}, 32'(c_pfx), e.c_pfx);
            end
`ifdef SEQDET_MATCH_COUNT_EN
            chk({tag, " a_cnt"}, 32'(a_cnt), e.a_cnt);
            if (e.chk_c)
                chk({tag, " c_cnt"}, 32'(c_cnt), e.c_cnt);
`endif
        end
    endtask

    // Brute-force reference: longest prefix of 1011 (up to 3 bits) ending the history.
    function automatic int model_k(logic [15:0] h, int n);
        int          k;
        logic [15:0] mask;
        logic [15:0] pre;
        k = 0;
        for (int j = 1; j <= 3; j++) begin
            mask = (16'd1 << j) - 16'd1;
            pre  = 16'h000b >> (4 - j);
            if (n >= j && (h & mask) == pre)
                k = j;
        end
        return k;
    endfunction

    initial begin
        logic [15:0] ha, hb;
        int          na, nb, acnt;
        logic        ma, mb;
        vec_t        v;

        vecs[0]  = mk(1,0,0,0, 0,0,0,0,0,0, 0,0);
        vecs[1]  = mk(0,1,1,0, 0,1,0,1,0,1, 0,0);
        vecs[2]  = mk(0,1,0,0, 0,2,0,2,0,0, 0,0);
        vecs[3]  = mk(0,1,1,0, 0,3,0,3,0,1, 0,0);
        vecs[4]  = mk(0,1,1,0, 1,1,1,0,1,1, 1,1);
        vecs[5]  = mk(0,1,0,0, 0,2,0,0,0,0, 1,1);
        vecs[6]  = mk(0,1,1,0, 0,3,0,1,0,1, 1,1);
        vecs[7]  = mk(0,1,1,0, 1,1,0,1,1,1, 2,2);
        vecs[8]  = mk(1,1,1,0, 0,0,0,0,0,0, 0,0);
        vecs[9]  = mk(0,1,1,0, 0,1,0,1,0,1, 0,0);
        vecs[10] = mk(0,1,0,0, 0,2,0,2,0,0, 0,0);
        vecs[11] = mk(0,1,1,0, 0,3,0,3,0,1, 0,0);
        vecs[12] = mk(0,1,0,0, 0,2,0,2,0,0, 0,0);
        vecs[13] = mk(0,1,1,0, 0,3,0,3,0,1, 0,0);
        vecs[14] = mk(0,1,1,0, 1,1,1,0,1,1, 1,1);
        vecs[15] = mk(1,0,0,0, 0,0,0,0,0,0, 0,0);
        vecs[16] = mk(0,0,1,0, 0,0,0,0,0,0, 0,0);
        vecs[17] = mk(0,1,1,0, 0,1,0,1,0,1, 0,0);
        vecs[18] = mk(0,0,0,0, 0,1,0,1,0,1, 0,0);
        vecs[19] = mk(0,0,1,0, 0,1,0,1,0,1, 0,0);
        vecs[20] = mk(0,1,0,0, 0,2,0,2,0,0, 0,0);
        vecs[21] = mk(0,0,1,0, 0,2,0,2,0,0, 0,0);
        vecs[22] = mk(0,1,1,0, 0,3,0,3,0,1, 0,0);
        vecs[23] = mk(0,0,1,0, 0,3,0,3,0,1, 0,0);
        vecs[24] = mk(0,1,1,0, 1,1,1,0,1,1, 1,1);
        vecs[25] = mk(0,0,1,0, 0,1,0,0,0,1, 1,1);
        vecs[26] = mk(0,1,0,0, 0,2,0,0,0,0, 1,1);
        vecs[27] = mk(0,1,1,0, 0,3,0,1,0,1, 1,1);
        vecs[28] = mk(1,1,1,0, 0,0,0,0,0,0, 0,0);
        vecs[29] = mk(0,1,1,0, 0,1,0,1,0,1, 0,0);
        vecs[30] = mk(0,1,1,0, 0,1,0,1,1,1, 0,1);
        vecs[31] = mk(0,1,1,0, 0,1,0,1,1,1, 0,2);
        vecs[32] = mk(0,1,1,0, 0,1,0,1,1,1, 0,3);
        vecs[33] = mk(0,1,1,0, 0,1,0,1,1,1, 0,3);
        vecs[34] = mk(0,1,1,0, 0,1,0,1,1,1, 0,3);
        vecs[35] = mk(0,1,1,1, 0,1,0,1,1,1, 0,0);
        vecs[36] = mk(0,1,1,0, 0,1,0,1,1,1, 0,1);
        vecs[37] = mk(0,0,1,0, 0,1,0,1,0,1, 0,1);

        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 38; i++)
            step(vecs[i], $sformatf("v%0d", i));

        // Random stream for the two 1011 detectors against a history-based model.
        ha = '0; hb = '0; na = 0; nb = 0; acnt = 0;
        for (int i = 0; i < 400; i++) begin
            v = mk(0,0,0,0, 0,0,0,0,0,0, 0,0);
            v.chk_c = 1'b0;
            v.rst   = (i == 0) || ($urandom_range(0, 59) == 0);
            v.en    = ($urandom_range(0, 3) != 0);
            v.din   = $urandom_range(0, 1) != 0;
            if (v.rst) begin
                ha = '0; hb = '0; na = 0; nb = 0; acnt = 0;
            end else if (v.en) begin
                ha = {ha[14:0], v.din}; na = (na < 16) ? na + 1 : 16;
                hb = {hb[14:0], v.din}; nb = (nb < 16) ? nb + 1 : 16;
                ma = (na >= 4) && (ha[3:0] == 4'b1011);
                mb = (nb >= 4) && (hb[3:0] == 4'b1011);
                if (mb) nb = 0;
                if (ma && acnt < 255) acnt++;
                v.a_det = ma;
                v.b_det = mb;
            end
            v.a_pfx = model_k(ha, na);
            v.b_pfx = model_k(hb, nb);
            v.a_cnt = acnt;
            step(v, $sformatf("r%0d", i));
        end

        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard drain: got %0d leftover expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
